// File: rtl/tree_walk_ctrl.sv
// tree_walk_ctrl
//   Walks a binary decision tree stored in a ROM with registered reads.
//   The walk starts at address 0. Each node takes two cycles: FETCH presents
//   the address, and EVAL sees the node word. In EVAL an internal node
//   compares the selected feature against its threshold and steps to the
//   left or right child. A leaf returns its tag as the class. A walk aborts
//   with res_err on an id mismatch, an out-of-range child address or a walk
//   that is too deep.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         walk request, accepted when start && start_ready
//   start_ready   high only while idle
//   rom_addr      tree ROM address; node_data is valid one cycle later
//   node_data     ROM node word
//   feat_sel      feature index for the node being evaluated
//   feat_val      IEEE-754 double for feat_sel, returned in the same cycle
//   res_valid     result valid, held until res_ready
//   res_ready     result consumed
//   res_class     leaf class (0 on error)
//   res_err       walk aborted
//   res_depth     number of internal nodes visited
module tree_walk_ctrl #(
  parameter int NODE_WIDTH = 120,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_DEPTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  start_ready,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [NODE_WIDTH-1:0] node_data,
  output logic [3:0]            feat_sel,
  input  logic [63:0]           feat_val,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [3:0]            res_class,
  output logic                  res_err,
  output logic [5:0]            res_depth
);

  typedef enum logic [2:0] {IDLE, FETCH, EVAL, DONE, ERR} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [5:0]            depth_reg, depth_next;
  logic [3:0]            feat_reg, feat_next;
  logic [3:0]            class_reg, class_next;
  logic                  err_reg, err_next;
  logic [5:0]            rdepth_reg, rdepth_next;

  // Node word fields
  logic [11:0] node_id;
  logic [3:0]  node_feat;
  logic [63:0] node_thr;
  logic [11:0] node_left, node_right;
  logic [3:0]  node_tag;

  assign node_id    = node_data[107:96];
  assign node_feat  = node_data[95:92];
  assign node_thr   = node_data[91:28];
  assign node_left  = node_data[27:16];
  assign node_right = node_data[15:4];
  assign node_tag   = node_data[3:0];

  // The bits above the node_id field carry no meaning for the walk.
  generate
    if (NODE_WIDTH > 108) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^node_data[NODE_WIDTH-1:108];
    end
  endgenerate

  // Total-order key for doubles: negative values are bit-inverted and
  // positive values have their sign bit set. After that, an unsigned
  // compare orders them, so -0.0 < +0.0 and NaNs sort by their raw bits.
  function automatic logic [63:0] order_key(input logic [63:0] x);
    return x[63] ? ~x : (x ^ 64'h8000_0000_0000_0000);
  endfunction

  logic        is_leaf, id_match, go_left, child_oob;
  logic [11:0] next_child;

  assign is_leaf    = (node_left == 12'd0) && (node_right == 12'd0);
  assign id_match   = 32'(node_id) == 32'(addr_reg);
  assign go_left    = order_key(feat_val) <= order_key(node_thr);
  assign next_child = go_left ? node_left : node_right;
  // Any child bit at or above ADDR_WIDTH points outside the ROM.
  assign child_oob  = (next_child >> ADDR_WIDTH) != 12'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      depth_reg  <= '0;
      feat_reg   <= '0;
      class_reg  <= '0;
      err_reg    <= 1'b0;
      rdepth_reg <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      depth_reg  <= depth_next;
      feat_reg   <= feat_next;
      class_reg  <= class_next;
      err_reg    <= err_next;
      rdepth_reg <= rdepth_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    depth_next  = depth_reg;
    feat_next   = feat_reg;
    class_next  = class_reg;
    err_next    = err_reg;
    rdepth_next = rdepth_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next  = '0;
          depth_next = '0;
          err_next   = 1'b0;
          state_next = FETCH;
        end
      end
      FETCH: state_next = EVAL;
      EVAL: begin
        // feat_sel keeps showing the last evaluated node's feature afterwards.
        feat_next = node_feat;
        if (!id_match) begin
          state_next = ERR;
        end else if (is_leaf) begin
          class_next  = node_tag;
          rdepth_next = depth_reg;
          state_next  = DONE;
        end else if (child_oob || (depth_reg == 6'(MAX_DEPTH))) begin
          state_next = ERR;
        end else begin
          addr_next  = ADDR_WIDTH'(next_child);
          depth_next = depth_reg + 6'd1;
          state_next = FETCH;
        end
      end
      ERR: begin
        err_next    = 1'b1;
        class_next  = 4'd0;
        rdepth_next = depth_reg;
        state_next  = DONE;
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign start_ready = (state_reg == IDLE);
  assign res_valid   = (state_reg == DONE);
  assign rom_addr    = addr_reg;
  // In EVAL the feature index goes straight to the feature source, because
  // feat_val has to come back in the same cycle.
  assign feat_sel    = (state_reg == EVAL) ? node_feat : feat_reg;
  assign res_class   = class_reg;
  assign res_err     = err_reg;
  assign res_depth   = rdepth_reg;

endmodule

// File: doc/tree_walk_ctrl.md
TREE_WALK_CTRL -- requirements
Module: tree_walk_ctrl

Interface
- REQ-001: The block SHALL have one clock and a synchronous, active-high reset; there SHALL be no other clock or asynchronous input.
- REQ-002: Parameter NODE_WIDTH, default 120, SHALL be the node word width.
- REQ-003: Parameter ADDR_WIDTH, default 10, SHALL be the ROM address width.
- REQ-004: Parameter MAX_DEPTH, default 32, SHALL be the maximum number of internal nodes visited per walk.
- REQ-005: Ports (name, direction, width, meaning):
  - clk, in, 1: clock.
  - rst, in, 1: synchronous active-high reset.
  - start, in, 1: walk request.
  - start_ready, out, 1: request accepted when start and start_ready are both high.
  - rom_addr, out, ADDR_WIDTH: address to the tree ROM.
  - node_data, in, NODE_WIDTH: ROM data, valid one cycle after rom_addr.
  - feat_sel, out, 4: feature index.
  - feat_val, in, 64: IEEE-754 double for feat_sel, combinational, same cycle.
  - res_valid, out, 1: result valid.
  - res_ready, in, 1: result consumed.
  - res_class, out, 4: leaf class.
  - res_err, out, 1: walk aborted.
  - res_depth, out, 6: number of internal nodes visited.

Function
- REQ-006: The node word fields SHALL be:
  - [107:96] node_id.
  - [95:92] feature.
  - [91:28] threshold (double).
  - [27:16] left child.
  - [15:4] right child.
  - [3:0] tag.
  - Bits above 107 SHALL be ignored.
- REQ-007: A node SHALL be a leaf when left == 0 and right == 0; a leaf's class SHALL be tag.
- REQ-008: The FSM SHALL have the states IDLE, FETCH, EVAL, DONE and ERR; start_ready SHALL be high only in IDLE.
- REQ-009: In IDLE, on acceptance, the block SHALL load rom_addr = 0 and depth = 0, then go to FETCH.
- REQ-010: FETCH SHALL hold rom_addr for one cycle and then go to EVAL, which absorbs the one-cycle ROM latency.
- REQ-011: EVAL checks (first match applies):
  - node_id != rom_addr (zero-extended): go to ERR.
  - Leaf: latch res_class = tag, go to DONE.
  - Otherwise: drive feat_sel = feature and continue with REQ-013.
- REQ-012: Comparison SHALL use order keys key(x) = x[63] ? ~x : x ^ 2^63, compared as unsigned 64-bit values. Consequences: -0.0 < +0.0, and NaN is ordered by its raw bits with no special handling.
- REQ-013: EVAL branching:
  - key(feat_val) <= key(threshold): next = left child; otherwise next = right child.
  - next[11:ADDR_WIDTH] != 0, or depth == MAX_DEPTH: go to ERR.
  - Otherwise: rom_addr <= next[ADDR_WIDTH-1:0], depth <= depth + 1, go to FETCH.
- REQ-014: ERR SHALL latch res_err = 1 and res_class = 0, then go to DONE on the next cycle.
- REQ-015: In DONE, res_valid SHALL be high. The block SHALL return to IDLE on the cycle where res_valid and res_ready are both high. res_class, res_err and res_depth SHALL be stable while res_valid is high and res_ready is low.
- REQ-016: For a walk that ends at a leaf after k nodes (k-1 internal nodes), res_valid SHALL rise 2k edges after the accepting edge, and res_depth SHALL equal k-1.
- REQ-017: start SHALL be ignored outside IDLE; a start that is pending in DONE SHALL be accepted no earlier than the cycle after the handshake.
- REQ-018: feat_sel SHALL equal the feature field of node_data in EVAL and SHALL hold its last value in all other states.

Reset
- REQ-019: When rst is high at a clock edge, the block SHALL enter IDLE and clear to 0: rom_addr, feat_sel, res_valid, res_class, res_err, res_depth and the internal depth.
- REQ-020: A reset in any state, including mid-walk or DONE with res_ready low, SHALL abandon the walk with no result produced; start_ready SHALL be high on the first cycle after rst is released.

Verification
- REQ-021: ROM model with node0 (feature 0, threshold 0x41D8EC3390000000, children 0x001/0x0A0), node1 (feature 1, threshold 0x4068100000000000, children 0x002/0x003) and node2 (leaf, tag 1); inputs feat0 = 0.0, feat1 = 0x4068000000000000 -> res_valid rises 6 edges after acceptance, with res_class = 1, res_depth = 2, res_err = 0.
- REQ-022: Same ROM model with feat0 = 0xBFF0000000000000 (-1.0) versus threshold 0x3FF0000000000000 at the root -> left child taken; with feat0 = 0x7FF0000000000000 (+inf) -> right child taken.
- REQ-023: Node word with node_id 0x005 read at rom_addr 0x004 -> res_err = 1, res_class = 0.
- REQ-024: A 40-node left-only chain with MAX_DEPTH = 32 -> res_err = 1 and res_depth = 32; a child value of 0x400 with ADDR_WIDTH = 10 -> res_err = 1.
- REQ-025: res_ready held low for 5 cycles in DONE -> outputs stable and start ignored; rst pulsed during FETCH of the second node -> IDLE, res_valid stays 0, and the next walk completes correctly.
